pwm_multi_ch: RTL
=================

Name: pwm_multi_ch

Overview:
Multi-channel PWM generator, the parametrised successor to the single-output LED blinker/PWM block. One shared period counter drives CH independent compare channels. Each channel has its own duty value and output polarity. Period and duty are double-buffered and take effect only at a period boundary, so outputs never glitch. Sits between a register/control block (or board switches) and LED or motor-driver pins.

Parameters:
CH, 4, number of PWM output channels (1..16)
CNT_W, 16, width of the period counter and of each duty value (4..32)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  run enable; low = counter held, outputs at idle level
period  input  CNT_W  terminal count P; PWM period is P+1 clk cycles
duty  input  CH*CNT_W  packed duty values, channel i at bits [i*CNT_W +: CNT_W]
load  input  1  single-cycle strobe; captures period and duty into the pending buffers
pol  input  CH  per-channel polarity; 1 = invert output
pwm_out  output  CH  registered PWM outputs
cyc_start  output  1  one-cycle pulse when the counter restarts at 0
pending  output  1  high while captured values are waiting to be applied

Behaviour:
- Reset (async assert, sync release): cnt=0; active and pending period and duty = 0; pending=0; pwm_out=0; cyc_start=0.
- Counter (en=1): cnt increments each clk. When cnt==period_act, cnt wraps to 0 on the next edge.
- cyc_start is registered. It is 1 in the cycle where cnt==0 following a wrap or following en rising.
- Channel compare: raw_i = (cnt < duty_act_i), unsigned CNT_W compare.
- pwm_out_i is registered from raw_i ^ pol_i, giving 1 clk latency from cnt.
- duty_act_i = 0 gives a constant inactive level.
- duty_act_i > period_act gives a constant active level (100%).
- High time is duty_act_i cycles out of period_act+1.
- Double buffering:
  - load=1 samples period and duty into the pending registers and sets pending=1.
  - At wrap (en=1 and cnt==period_act), pending values copy to active and pending clears. The new values govern the cycle starting at cnt=0.
  - load in the same cycle as wrap: the freshly sampled inputs go directly to active and pending stays 0.
  - load while pending=1: the pending registers are overwritten; the last load wins.
- Enable low:
  - cnt is forced to 0 and pwm_out_i = pol_i (inactive level), registered.
  - Any pending values copy to active immediately; pending clears.
  - load while en=0 goes straight to active.
  - When en rises, counting starts from cnt=0 and cyc_start pulses.
- Period 0: every cycle is a wrap. Output is 1 for duty_act ≥ 1, otherwise 0 (before pol). cyc_start is held high continuously.
- Period reduced below the current cnt: impossible, because the period changes only at wrap or while disabled.
- Reset mid-period: all state clears immediately. No partial pulse is required after release.
- All arithmetic is unsigned. No multipliers; the compare is a direct magnitude comparison.

Decomposition:
- Package pwm_pkg holds:
  - default CNT_W and CH constants;
  - a function for the packed-duty slice index;
  - a localparam for the idle output level convention.
- Sub-module pwm_channel, instantiated CH times by generate. It contains:
  - the pending and active duty registers;
  - the compare;
  - the polarity XOR;
  - the output register.
- The top level contains the counter, the period buffers, the pending flag and cyc_start.

Test Plan:
1. Reset then run: CNT_W=8, period=9, duty0=3, pol=0, load, en=1. Required: after the first wrap, pwm_out[0] is high 3 of every 10 cycles and cyc_start pulses every 10 cycles.
2. Boundary duties: duty1=0 and duty2=12 with period=9. Required: ch1 is constant 0 and ch2 is constant 1. With pol=0b0110, ch1 is constant 1 and ch2 is constant 0.
3. Glitch-free update: mid-period (cnt=4), load period=4, duty0=2. Required: pending=1, the current 10-cycle period completes unchanged, then 5-cycle periods with 2 high cycles; pending clears at the wrap.
4. Load on wrap cycle plus a double load: assert load exactly when cnt==period. Required: new values apply from the next cnt=0 and pending stays 0. Then load twice within one period (duty0=1, then duty0=4). Required: only 4 takes effect.
5. Enable toggle: drop en at cnt=6. Required: the next pwm_out is pol and cnt=0. Load while disabled. Required: values apply at once. Raise en. Required: cyc_start pulses and counting restarts from 0.
6. Async reset mid-run: assert rst between clock edges. Required: pwm_out=0, pending=0 and cyc_start=0 immediately. Period 0 after release with duty0=1. Required: pwm_out[0] constant 1 and cyc_start constant 1.

Source files
------------

// File: rtl/pwm_multi_ch_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

   localparam int unsigned DEF_CH    = 4;
   localparam int unsigned DEF_CNT_W = 16;

   // Output level before polarity inversion when a channel is idle (disabled).
   localparam logic IDLE_LVL = 1'b0;

   function automatic int unsigned duty_lsb(input int unsigned ch, input int unsigned w);
      return ch * w;
   endfunction

endpackage

// File: rtl/pwm_multi_ch_if.sv
// Control/status bundle between the register block and the PWM generator.
interface pwm_multi_ch_if
   import pwm_pkg::*;
#(
   parameter int unsigned CH    = DEF_CH,
   parameter int unsigned CNT_W = DEF_CNT_W
);
   logic                  en;
   logic [CNT_W-1:0]      period;
   logic [CH*CNT_W-1:0]   duty;
   logic                  load;
   logic [CH-1:0]         pol;
   logic [CH-1:0]         pwm_out;
   logic                  cyc_start;
   logic                  pending;

   modport master (
      output en, period, duty, load, pol,
      input  pwm_out, cyc_start, pending
   );

   modport slave (
      input  en, period, duty, load, pol,
      output pwm_out, cyc_start, pending
   );
endinterface

// File: rtl/pwm_multi_ch_channel.sv
// One PWM compare channel: double-buffered duty, magnitude compare, polarity, output register.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_load,
   input  logic             i_apply,
   input  logic             i_pending,
   input  logic [CNT_W-1:0] i_duty,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic             i_pol,
   output logic             o_pwm
);
   logic [CNT_W-1:0] r_duty_pend;
   logic [CNT_W-1:0] r_duty_act;
   logic             r_pwm;
   logic             w_raw;

   assign w_raw = (i_cnt < r_duty_act);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_duty_pend <= '0;
         r_duty_act  <= '0;
         r_pwm       <= 1'b0;
      end else begin
         // A load coinciding with an apply point bypasses the pending buffer.
         if (i_load && i_apply) begin
            r_duty_act <= i_duty;
         end else if (i_load) begin
            r_duty_pend <= i_duty;
         end else if (i_apply && i_pending) begin
            r_duty_act <= r_duty_pend;
         end
         r_pwm <= i_en ? (w_raw ^ i_pol) : (IDLE_LVL ^ i_pol);
      end
   end

   assign o_pwm = r_pwm;
endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared period counter, double-buffered period, CH compare channels.
module pwm_multi_ch
   import pwm_pkg::*;
#(
   parameter int unsigned CH    = DEF_CH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input logic           clk,
   input logic           rst,
   pwm_multi_ch_if.slave bus
);
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_per_act;
   logic [CNT_W-1:0] r_per_pend;
   logic             r_pending;
   logic             r_cyc_start;
   logic             w_wrap;
   logic             w_apply;
   logic [CH-1:0]    w_pwm;

   assign w_wrap  = bus.en && (r_cnt == r_per_act);
   assign w_apply = w_wrap || !bus.en;

   // cyc_start is registered from cnt==0 so it lines up with the first pwm_out cycle of a period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_cyc_start <= 1'b0;
      end else begin
         r_cyc_start <= bus.en && (r_cnt == '0);
         if (!bus.en || w_wrap) r_cnt <= '0;
         else                   r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_per_act  <= '0;
         r_per_pend <= '0;
         r_pending  <= 1'b0;
      end else begin
         if (bus.load && w_apply) begin
            r_per_act <= bus.period;
            r_pending <= 1'b0;
         end else if (bus.load) begin
            r_per_pend <= bus.period;
            r_pending  <= 1'b1;
         end else if (w_apply && r_pending) begin
            r_per_act <= r_per_pend;
            r_pending <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < CH; g++) begin : g_ch
      localparam int unsigned LSB = duty_lsb(g, CNT_W);
      pwm_channel #(.CNT_W(CNT_W)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_en      (bus.en),
         .i_load    (bus.load),
         .i_apply   (w_apply),
         .i_pending (r_pending),
         .i_duty    (bus.duty[LSB +: CNT_W]),
         .i_cnt     (r_cnt),
         .i_pol     (bus.pol[g]),
         .o_pwm     (w_pwm[g])
      );
   end

   assign bus.pwm_out   = w_pwm;
   assign bus.cyc_start = r_cyc_start;
   assign bus.pending   = r_pending;
endmodule
